// File: rtl/window_pkg.sv
// Shared definitions for the window engine: default widths, FSM states and
// the coefficient generator used to build the window table.
package window_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned COEF_W_DEF    = 8;
    localparam int unsigned ROM_DEPTH_DEF = 934;
    localparam int unsigned FRAC_W_DEF    = 6;
    localparam int unsigned NCH_DEF       = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Hann coefficient round((2^coef_w-1) * sin^2(pi*idx/(depth-1))), with the
    // sine taken from the Bhaskara rational approximation so the table can be
    // built from exact integer arithmetic at elaboration time.
    function automatic int unsigned hann_coef(input int unsigned idx,
                                              input int unsigned depth,
                                              input int unsigned coef_w);
        longint l;
        longint i;
        longint p;
        longint num;
        longint den;
        longint cmax;
        if (depth < 2) begin
            return 0;
        end
        l    = 64'(depth) - 64'd1;
        i    = 64'(idx);
        p    = i * (l - i);
        num  = 64'd16 * p;
        den  = 64'd5 * l * l - 64'd4 * p;
        cmax = (64'd1 << coef_w) - 64'd1;
        return 32'((64'd2 * cmax * num * num + den * den) / (64'd2 * den * den));
    endfunction

endpackage

// File: rtl/window_coef_rom.sv
// Window coefficient table with a registered read port.
// Ports: clock, addr (table index), coef (coefficient, one cycle after addr).
module window_coef_rom
    import window_pkg::*;
#(
    parameter  int unsigned COEF_W    = COEF_W_DEF,
    parameter  int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH)
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] addr,
    output logic [COEF_W-1:0] coef
);

    logic [COEF_W-1:0] table_c [ROM_DEPTH];

    // Constant table, folded at elaboration.
    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_tab
        assign table_c[g] = COEF_W'(hann_coef(32'(g), ROM_DEPTH, COEF_W));
    end

    // Addresses past the table read as zero rather than undefined.
    always_ff @(posedge clock) begin
        if (32'(addr) < ROM_DEPTH) begin
            coef <= table_c[addr];
        end else begin
            coef <= '0;
        end
    end

endmodule

// File: rtl/window_engine.sv
// Applies a stretchable Hann window to an interleaved multi-channel stream.
// Ports: clock/reset (sync, active-high); start, win_len, step configure a
// window; s_valid/s_ready/s_data input stream; m_valid/m_data/m_chan/m_last
// windowed output (2-cycle latency, no backpressure); busy, err status.
module window_engine
    import window_pkg::*;
#(
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned COEF_W    = COEF_W_DEF,
    parameter  int unsigned ROM_DEPTH = ROM_DEPTH_DEF,
    parameter  int unsigned FRAC_W    = FRAC_W_DEF,
    parameter  int unsigned NCH       = NCH_DEF,
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH),
    localparam int unsigned OUT_W     = DATA_W + COEF_W + 1,
    localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        win_len,
    input  logic [ADDR_W+FRAC_W-1:0] step,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    output logic                     m_valid,
    output logic signed [OUT_W-1:0]  m_data,
    output logic [CH_W-1:0]          m_chan,
    output logic                     m_last,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned PH_W = ADDR_W + FRAC_W;
    localparam logic [PH_W:0] PH_MAX = (PH_W+1)'((ROM_DEPTH - 1) << FRAC_W);

    state_t                     state;
    logic [ADDR_W-1:0]          len_q;
    logic [PH_W-1:0]            step_q;
    logic [PH_W-1:0]            ph;
    logic [ADDR_W-1:0]          cnt;
    logic [CH_W-1:0]            ch;

    logic                       v1;
    logic                       last1;
    logic [CH_W-1:0]            ch1;
    logic signed [DATA_W-1:0]   data1;
    logic [COEF_W-1:0]          coef;

    logic                       xfer_c;
    logic                       ch_wrap_c;
    logic                       last_xfer_c;
    logic [PH_W:0]              ph_sum_c;
    logic [PH_W-1:0]            ph_next_c;

    assign s_ready     = (state == RUN);
    assign busy        = (state != IDLE);
    assign xfer_c      = s_valid && s_ready;
    assign ch_wrap_c   = (ch == CH_W'(NCH - 1));
    assign last_xfer_c = ch_wrap_c && (cnt == len_q - ADDR_W'(1));

    // Phase advance with one guard bit so overflow saturates instead of wrapping.
    assign ph_sum_c  = {1'b0, ph} + {1'b0, step_q};
    assign ph_next_c = (ph_sum_c > PH_MAX) ? PH_MAX[PH_W-1:0] : ph_sum_c[PH_W-1:0];

    // Coefficient lookup is registered alongside the incoming sample (stage 1).
    window_coef_rom #(
        .COEF_W   (COEF_W),
        .ROM_DEPTH(ROM_DEPTH)
    ) u_rom (
        .clock(clock),
        .addr (ph[PH_W-1:FRAC_W]),
        .coef (coef)
    );

    // Control FSM, phase accumulator and two-stage multiply pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            len_q   <= '0;
            step_q  <= '0;
            ph      <= '0;
            cnt     <= '0;
            ch      <= '0;
            err     <= 1'b0;
            v1      <= 1'b0;
            last1   <= 1'b0;
            ch1     <= '0;
            data1   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            m_last  <= 1'b0;
        end else begin
            err <= 1'b0;

            v1 <= xfer_c;
            if (xfer_c) begin
                data1 <= s_data;
                ch1   <= ch;
                last1 <= last_xfer_c;
            end

            m_valid <= v1;
            m_last  <= v1 && last1;
            if (v1) begin
                m_data <= OUT_W'(data1) * OUT_W'($signed({1'b0, coef}));
                m_chan <= ch1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (win_len >= ADDR_W'(2)) begin
                            len_q  <= win_len;
                            step_q <= step;
                            ph     <= '0;
                            cnt    <= '0;
                            ch     <= '0;
                            state  <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer_c) begin
                        if (ch_wrap_c) begin
                            ch  <= '0;
                            cnt <= cnt + ADDR_W'(1);
                            ph  <= ph_next_c;
                        end else begin
                            ch <= ch + CH_W'(1);
                        end
                        if (last_xfer_c) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means the final product is on the output now.
                    if (!v1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_engine.sv
// Directed bench for window_engine: table of windows on a single-channel
// instance plus hand-written error, reset and two-channel sequences.
module tb_window_engine;

    localparam int DEPTH = 934;

    typedef struct {
        int len;
        int step;
        int val;
        int gap;
        bit poke;
        int exp_outs;
        int exp_last_addr;
    } vec_t;

    typedef struct {
        logic signed [24:0] data;
        int                 chan;
        bit                 last;
    } out_t;

    logic clock = 1'b0;
    logic reset;

    logic               start1, s_valid1, s_ready1, m_valid1, m_last1, busy1, err1;
    logic [9:0]         win_len1;
    logic [15:0]        step1;
    logic signed [15:0] s_data1;
    logic signed [24:0] m_data1;
    logic [0:0]         m_chan1;

    logic               start2, s_valid2, s_ready2, m_valid2, m_last2, busy2, err2;
    logic [9:0]         win_len2;
    logic [15:0]        step2;
    logic signed [15:0] s_data2;
    logic signed [24:0] m_data2;
    logic [0:0]         m_chan2;

    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    out_t q1[$];
    out_t q2[$];
    vec_t vecs[5];

    window_engine #(.DATA_W(16), .COEF_W(8), .ROM_DEPTH(DEPTH), .FRAC_W(6), .NCH(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .win_len(win_len1), .step(step1),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .m_valid(m_valid1), .m_data(m_data1), .m_chan(m_chan1), .m_last(m_last1),
        .busy(busy1), .err(err1)
    );

    window_engine #(.DATA_W(16), .COEF_W(8), .ROM_DEPTH(DEPTH), .FRAC_W(6), .NCH(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .win_len(win_len2), .step(step2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_data(m_data2), .m_chan(m_chan2), .m_last(m_last2),
        .busy(busy2), .err(err2)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (m_valid1) q1.push_back('{m_data1, int'(m_chan1), m_last1});
        if (m_valid2) q2.push_back('{m_data2, int'(m_chan2), m_last2});
        if (err1) err_pulses++;
    end

    // Reference Hann value from floating-point arithmetic.
    function automatic longint ref_coef(input int i);
        real l, x, p, s;
        l = real'(DEPTH - 1);
        x = real'(i) / l;
        p = x * (1.0 - x);
        s = 16.0 * p / (5.0 - 4.0 * p);
        return longint'($floor(255.0 * s * s + 0.5));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_idle1(input string name);
        int b;
        b = 0;
        while (busy1 && b < 50) begin
            @(posedge clock); #1;
            b++;
        end
        check(name, longint'(busy1), 0);
    endtask

    task automatic run_window(input vec_t v, input int id);
        int ph;
        int pulses0;
        int exp_addr[$];
        q1.delete();
        pulses0 = err_pulses;
        @(posedge clock); #1;
        start1 = 1'b1; win_len1 = 10'(v.len); step1 = 16'(v.step);
        @(posedge clock); #1;
        start1 = 1'b0; win_len1 = 10'd1;
        check($sformatf("v%0d_busy", id), longint'(busy1), 1);
        ph = 0;
        for (int n = 0; n < v.len; n++) begin
            if (v.gap != 0 && (n % v.gap) == v.gap - 1) begin
                s_valid1 = 1'b0;
                @(posedge clock); #1;
            end
            if (v.poke && n == 3) start1 = 1'b1;
            s_valid1 = 1'b1;
            s_data1  = 16'(v.val);
            @(posedge clock); #1;
            start1 = 1'b0;
            exp_addr.push_back(ph / 64);
            ph = ph + v.step;
            if (ph > (DEPTH - 1) * 64) ph = (DEPTH - 1) * 64;
        end
        s_valid1 = 1'b0;
        wait_idle1($sformatf("v%0d_idle", id));
        check($sformatf("v%0d_count", id), q1.size(), v.exp_outs);
        check($sformatf("v%0d_err", id), err_pulses - pulses0, 0);
        for (int i = 0; i < q1.size() && i < exp_addr.size(); i++) begin
            check($sformatf("v%0d_data%0d", id, i), longint'(q1[i].data),
                  longint'(v.val) * ref_coef(exp_addr[i]));
            check($sformatf("v%0d_last%0d", id, i), longint'(q1[i].last),
                  (i == v.len - 1) ? 1 : 0);
            check($sformatf("v%0d_chan%0d", id, i), q1[i].chan, 0);
        end
        if (q1.size() > 0)
            check($sformatf("v%0d_final", id), longint'(q1[q1.size()-1].data),
                  longint'(v.val) * ref_coef(v.exp_last_addr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int din[6];
        int b;
        din = '{100, -100, 200, -200, 300, -300};

        vecs[0] = '{934, 64,    32767,  0, 1'b0, 934, 933};
        vecs[1] = '{467, 128,   -5000,  7, 1'b0, 467, 932};
        vecs[2] = '{400, 200,   1234,   0, 1'b0, 400, 933};
        vecs[3] = '{10,  96,    -32768, 3, 1'b1, 10,  13};
        vecs[4] = '{2,   29824, 7,      0, 1'b0, 2,   466};

        reset = 1'b1;
        start1 = 1'b0; win_len1 = '0; step1 = '0; s_valid1 = 1'b0; s_data1 = '0;
        start2 = 1'b0; win_len2 = '0; step2 = '0; s_valid2 = 1'b0; s_data2 = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_m_valid", longint'(m_valid1), 0);
        check("rst_m_last",  longint'(m_last1), 0);
        check("rst_m_data",  longint'(m_data1), 0);
        check("rst_m_chan",  longint'(m_chan1), 0);
        check("rst_busy",    longint'(busy1), 0);
        check("rst_err",     longint'(err1), 0);
        check("rst_s_ready", longint'(s_ready1), 0);
        reset = 1'b0;

        // Rejected start: one-cycle err, FSM stays idle.
        @(posedge clock); #1;
        start1 = 1'b1; win_len1 = 10'd1; step1 = 16'd64;
        @(posedge clock); #1;
        start1 = 1'b0;
        check("err_pulse", longint'(err1), 1);
        check("err_busy0", longint'(busy1), 0);
        @(posedge clock); #1;
        check("err_clear", longint'(err1), 0);
        check("err_busy1", longint'(busy1), 0);
        check("err_ready", longint'(s_ready1), 0);

        run_window(vecs[0], 0);
        run_window(vecs[1], 1);

        // Reset after the 5th transfer of a 10-sample window.
        q1.delete();
        @(posedge clock); #1;
        start1 = 1'b1; win_len1 = 10'd10; step1 = 16'd64;
        @(posedge clock); #1;
        start1 = 1'b0;
        for (int n = 0; n < 5; n++) begin
            s_valid1 = 1'b1; s_data1 = 16'sd1000;
            @(posedge clock); #1;
        end
        s_valid1 = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rstmid_busy",    longint'(busy1), 0);
        check("rstmid_m_valid", longint'(m_valid1), 0);
        repeat (8) @(posedge clock);
        #1;
        check("rstmid_count", q1.size(), 4);

        run_window(vecs[2], 2);
        run_window(vecs[3], 3);
        run_window(vecs[4], 4);

        // Two interleaved channels share one coefficient per sample period.
        q2.delete();
        @(posedge clock); #1;
        start2 = 1'b1; win_len2 = 10'd3; step2 = 16'd12800;
        @(posedge clock); #1;
        start2 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            s_valid2 = 1'b1; s_data2 = 16'(din[n]);
            @(posedge clock); #1;
        end
        s_valid2 = 1'b0;
        b = 0;
        while (busy2 && b < 50) begin
            @(posedge clock); #1;
            b++;
        end
        check("ch2_idle", longint'(busy2), 0);
        check("ch2_count", q2.size(), 6);
        for (int i = 0; i < q2.size() && i < 6; i++) begin
            check($sformatf("ch2_data%0d", i), longint'(q2[i].data),
                  longint'(din[i]) * ref_coef(200 * (i / 2)));
            check($sformatf("ch2_chan%0d", i), q2[i].chan, i % 2);
            check($sformatf("ch2_last%0d", i), longint'(q2[i].last), (i == 5) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_engine.md
WINDOW_ENGINE -- requirements
Module: window_engine

Interface
REQ-001 Parameter DATA_W, default 16: signed input sample width.
REQ-002 Parameter COEF_W, default 8: unsigned Hann coefficient width, Q0.COEF_W.
REQ-003 Parameter ROM_DEPTH, default 934: coefficient entries, covering twice the longest pitch period.
REQ-004 Parameter FRAC_W, default 6: fractional bits of the phase step.
REQ-005 Parameter NCH, default 1: interleaved channel count, 1..8.
REQ-006 Derived: ADDR_W = clog2(ROM_DEPTH); OUT_W = DATA_W+COEF_W+1; CH_W = max(1, clog2(NCH)).
REQ-007 clock  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse that begins a window.
REQ-009 win_len  in  ADDR_W  window length in sample periods, sampled at start.
REQ-010 step  in  ADDR_W+FRAC_W  unsigned fixed-point ROM phase increment, sampled at start.
REQ-011 s_valid  in  1; s_ready  out  1; s_data  in  DATA_W signed: interleaved input, channel 0 first.
REQ-012 m_valid  out  1; m_data  out  OUT_W signed; m_chan  out  CH_W; m_last  out  1.
REQ-013 busy  out  1  high outside IDLE; err  out  1  one-cycle pulse on a rejected start.

Function
REQ-014 The FSM SHALL use states IDLE, RUN and DRAIN.
REQ-015 In IDLE, start with win_len >= 2 SHALL latch win_len and step, clear phase, sample count and channel index, and enter RUN on the next cycle.
REQ-016 In IDLE, start with win_len < 2 SHALL pulse err for one cycle and leave the FSM in IDLE.
REQ-017 start in RUN or DRAIN SHALL be ignored and SHALL NOT pulse err.
REQ-018 s_ready SHALL equal (state == RUN); a sample transfers on s_valid && s_ready.
REQ-019 The ROM address SHALL be phase[ADDR_W+FRAC_W-1:FRAC_W], truncated.
REQ-020 The channel index SHALL increment on each transfer; on a transfer at index NCH-1 it SHALL wrap to 0, the sample count SHALL increment, and phase SHALL advance by step.
REQ-021 Phase SHALL saturate at (ROM_DEPTH-1)<<FRAC_W and SHALL never wrap.
REQ-022 All NCH channels of one sample period SHALL use the same coefficient.
REQ-023 The ROM read SHALL be registered; the incoming sample SHALL be registered alongside the address.
REQ-024 m_data SHALL be the registered product: s_data multiplied by the zero-extended coefficient, at full OUT_W precision with no rounding.
REQ-025 Latency SHALL be exactly 2 cycles: a transfer at edge k produces m_valid at edge k+2.
REQ-026 m_chan SHALL carry the channel index of the transfer.
REQ-027 m_last SHALL be high on the output from channel NCH-1 of sample period win_len-1.
REQ-028 After the transfer of that sample, the FSM SHALL enter DRAIN, deassert s_ready, and return to IDLE once the pipeline is empty (2 cycles).
REQ-029 Outputs SHALL NOT be backpressured; m_valid is a one-cycle strobe per result.
REQ-030 When the FSM is in RUN and no transfer occurs, phase, count and channel SHALL hold.

Reset
REQ-031 During reset, m_valid, m_last, err and busy SHALL be 0, m_data and m_chan SHALL be 0, the FSM SHALL be in IDLE, and the pipeline valids SHALL be cleared.
REQ-032 Reset asserted mid-window SHALL discard in-flight products, and no m_valid SHALL follow reset deassertion.

Structure
REQ-033 The FSM state enum and the default width constants SHALL live in a shared package, window_pkg.
REQ-034 The coefficient table SHALL be a sub-module, window_coef_rom, with a synchronous read port and parameters COEF_W and ROM_DEPTH.
REQ-035 The FSM, phase accumulator and multiply pipeline SHALL reside in window_engine.

Verification
REQ-036 NCH=1, win_len=934, step=64 (1.0), 934 samples of +32767 -> 934 outputs equal to 32767*rom[i] for i=0..933, m_last on the 934th output.
REQ-037 win_len=467, step=128 -> coefficient addresses 0,2,4,...,932; exactly 467 outputs.
REQ-038 step=200, win_len=400 -> address clamps at 933 once the phase saturates; no wrap to a low address.
REQ-039 NCH=2, win_len=3, inputs 100,-100,200,-200,300,-300 -> channel pairs share a coefficient, m_chan alternates 0,1, m_last on the 6th output.
REQ-040 start with win_len=1 -> err pulses for 1 cycle, busy stays 0; start during RUN -> ignored.
REQ-041 reset after the 5th transfer of a 10-sample window -> no further m_valid, busy=0 one cycle later, and a fresh start then operates normally.
